// File: rtl/tlb_if.sv
// tlb_if: lookup/response and commit-write port bundle for tlb_unit.
interface tlb_if #(
    parameter int N_ENTRIES = 4,
    parameter int VPN_W     = 20,
    parameter int PPN_W     = 8,
    parameter int OFFSET_W  = 12
);
    logic                          lk_valid;
    logic [VPN_W+OFFSET_W-1:0]     lk_vaddr;
    logic                          lk_priv;
    logic                          rsp_valid;
    logic                          rsp_hit;
    logic                          rsp_miss;
    logic [PPN_W+OFFSET_W-1:0]     rsp_paddr;
    logic                          wen;
    logic [VPN_W-1:0]              wr_vpn;
    logic [PPN_W-1:0]              wr_ppn;
    logic                          flush;
    logic [$clog2(N_ENTRIES):0]    occupancy;
    modport master (
        output lk_valid, lk_vaddr, lk_priv, wen, wr_vpn, wr_ppn, flush,
        input  rsp_valid, rsp_hit, rsp_miss, rsp_paddr, occupancy
    );
    modport slave (
        input  lk_valid, lk_vaddr, lk_priv, wen, wr_vpn, wr_ppn, flush,
        output rsp_valid, rsp_hit, rsp_miss, rsp_paddr, occupancy
    );
endinterface

// File: rtl/tlb_unit.sv
// tlb_unit: fully-associative TLB with round-robin replacement, supervisor bypass
// and a registered single-cycle lookup response.
module tlb_unit #(
    parameter int N_ENTRIES = 4,
    parameter int VPN_W     = 20,
    parameter int PPN_W     = 8,
    parameter int OFFSET_W  = 12
) (
    input logic   clk,
    input logic   rst,
    tlb_if.slave  bus
);
    localparam int IW = $clog2(N_ENTRIES);
    localparam int PW = PPN_W + OFFSET_W;
    logic [N_ENTRIES-1:0] valid, hit_vec;
    logic [VPN_W-1:0]     vpn [N_ENTRIES];
    logic [PPN_W-1:0]     ppn [N_ENTRIES];
    logic [IW-1:0]        vp, w_idx, free_idx, tgt;
    logic [PPN_W-1:0]     lk_ppn;
    logic [VPN_W-1:0]     lk_vpn;
    logic                 w_hit, full, do_wr, lk_hit;
    assign lk_vpn = bus.lk_vaddr[VPN_W+OFFSET_W-1:OFFSET_W];
    // Descending scan so free_idx settles on the lowest invalid slot.
    always_comb begin
        hit_vec  = '0;
        lk_ppn   = '0;
        w_idx    = '0;
        free_idx = '0;
        w_hit    = 1'b0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            hit_vec[i] = valid[i] && vpn[i] == lk_vpn;
            if (hit_vec[i]) lk_ppn = ppn[i];
            if (valid[i] && vpn[i] == bus.wr_vpn) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
            if (!valid[i]) free_idx = IW'(i);
        end
    end
    assign lk_hit = |hit_vec;
    assign full   = &valid;
    assign do_wr  = bus.wen && !bus.flush;
    assign tgt    = w_hit ? w_idx : full ? vp : free_idx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid         <= '0;
            vp            <= '0;
            bus.occupancy <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_miss  <= 1'b0;
            bus.rsp_paddr <= '0;
        end else begin
            bus.rsp_valid <= bus.lk_valid;
            bus.rsp_miss  <= bus.lk_valid && !(bus.lk_priv || lk_hit);
            if (bus.lk_valid) begin
                bus.rsp_hit   <= bus.lk_priv || lk_hit;
                bus.rsp_paddr <= bus.lk_priv ? bus.lk_vaddr[PW-1:0] :
                                 lk_hit ? {lk_ppn, bus.lk_vaddr[OFFSET_W-1:0]} : '0;
            end
            if (bus.flush) begin
                valid         <= '0;
                vp            <= '0;
                bus.occupancy <= '0;
            end else if (bus.wen) begin
                valid[tgt] <= 1'b1;
                if (!w_hit && full) vp <= vp + 1'b1;
                if (!w_hit && !full) bus.occupancy <= bus.occupancy + 1'b1;
            end
        end
    end
    // Table contents need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            vpn[tgt] <= bus.wr_vpn;
            ppn[tgt] <= bus.wr_ppn;
        end
    end
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed vector table, async-reset sequence and randomized run
// checked against an entry-array reference model of the translation buffer.
module tb_tlb_unit;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    tlb_if #(.N_ENTRIES(N)) bus ();
    tlb_unit #(.N_ENTRIES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] va;
        logic        pr;
        logic        w;
        logic [19:0] wv;
        logic [7:0]  wp;
        logic        fl;
        logic        ev, eh, em;
        logic [19:0] ep;
        int          eo, evp;
    } vec_t;

    vec_t tv[$];

    // reference model state
    logic        m_valid [N];
    logic [19:0] m_vpn [N];
    logic [7:0]  m_ppn [N];
    int          m_vp;
    logic        m_rv, m_hit, m_miss;
    logic [19:0] m_paddr;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic int m_occ();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_vp = 0; m_rv = 0; m_hit = 0; m_miss = 0; m_paddr = '0;
    endtask

    task automatic m_lookup(input logic [31:0] va, input logic pr);
        m_hit = pr;
        m_paddr = pr ? va[19:0] : 20'h0;
        if (!pr)
            for (int i = 0; i < N; i++)
                if (m_valid[i] && m_vpn[i] == va[31:12]) begin
                    m_hit = 1'b1;
                    m_paddr = {m_ppn[i], va[11:0]};
                end
    endtask

    task automatic m_write(input logic w, input logic [19:0] wv, input logic [7:0] wp, input logic fl);
        int j = -1;
        int k = -1;
        if (fl) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_vp = 0;
        end else if (w) begin
            for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == wv) j = i;
            for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) k = i;
            if (j >= 0) m_ppn[j] = wp;
            else begin
                if (k < 0) begin
                    k = m_vp;
                    m_vp = (m_vp + 1) % N;
                end
                m_valid[k] = 1'b1;
                m_vpn[k] = wv;
                m_ppn[k] = wp;
            end
        end
    endtask

    task automatic step(input logic lv, input logic [31:0] va, input logic pr, input logic w,
                        input logic [19:0] wv, input logic [7:0] wp, input logic fl);
        bus.lk_valid = lv; bus.lk_vaddr = va; bus.lk_priv = pr;
        bus.wen = w; bus.wr_vpn = wv; bus.wr_ppn = wp; bus.flush = fl;
        @(posedge clk);
        m_rv = lv;
        if (lv) m_lookup(va, pr);
        m_miss = lv && !m_hit;
        m_write(w, wv, wp, fl);
        #1;
    endtask

    task automatic chk_model(input string n);
        chk({n, " valid"}, 64'(bus.rsp_valid), 64'(m_rv));
        chk({n, " hit"},   64'(bus.rsp_hit),   64'(m_hit));
        chk({n, " miss"},  64'(bus.rsp_miss),  64'(m_miss));
        chk({n, " paddr"}, 64'(bus.rsp_paddr), 64'(m_paddr));
        chk({n, " occ"},   64'(bus.occupancy), 64'(m_occ()));
        chk({n, " vp"},    64'(dut.vp),        64'(m_vp));
    endtask

    function automatic vec_t mk(logic lv, logic [31:0] va, logic pr, logic w, logic [19:0] wv,
                                logic [7:0] wp, logic fl, logic ev, logic eh, logic em,
                                logic [19:0] ep, int eo, int evp);
        vec_t v;
        v.lv = lv; v.va = va; v.pr = pr; v.w = w; v.wv = wv; v.wp = wp; v.fl = fl;
        v.ev = ev; v.eh = eh; v.em = em; v.ep = ep; v.eo = eo; v.evp = evp;
        return v;
    endfunction

    // no lookup may ever match two entries
    always @(negedge clk) begin
        if (rst) begin
            ncmp++;
            if (!$onehot0(dut.hit_vec)) begin
                nerr++;
                $display("FAIL multi_match: hit_vec %b expected at most one bit", dut.hit_vec);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] rv;
        // bypass, cold miss, install, no forwarding, update in place
        tv.push_back(mk(1, 32'h00402ABC, 1, 0, 0, 0, 0,  1, 1, 0, 20'h02ABC, 0, 0));
        tv.push_back(mk(1, 32'h00402ABC, 0, 0, 0, 0, 0,  1, 0, 1, 20'h00000, 0, 0));
        tv.push_back(mk(1, 32'h00402ABC, 0, 1, 20'h00402, 8'h1F, 0,  1, 0, 1, 20'h00000, 1, 0));
        tv.push_back(mk(1, 32'h00402ABC, 0, 0, 0, 0, 0,  1, 1, 0, 20'h1FABC, 1, 0));
        tv.push_back(mk(0, 32'h0, 0, 1, 20'h00402, 8'h33, 0,  0, 1, 0, 20'h1FABC, 1, 0));
        tv.push_back(mk(1, 32'h00402ABC, 0, 0, 0, 0, 0,  1, 1, 0, 20'h33ABC, 1, 0));
        tv.push_back(mk(0, 32'h0, 0, 0, 0, 0, 1,  0, 1, 0, 20'h33ABC, 0, 0));
        // fill then round-robin wrap
        for (int k = 1; k <= 4; k++)
            tv.push_back(mk(0, 32'h0, 0, 1, 20'(k), 8'(k), 0,  0, 1, 0, 20'h33ABC, k, 0));
        for (int k = 5; k <= 9; k++)
            tv.push_back(mk(0, 32'h0, 0, 1, 20'(k), 8'(k), 0,  0, 1, 0, 20'h33ABC, 4, (k - 4) % 4));
        tv.push_back(mk(1, 32'h00001123, 0, 0, 0, 0, 0,  1, 0, 1, 20'h00000, 4, 1));
        tv.push_back(mk(1, 32'h00006456, 0, 0, 0, 0, 0,  1, 1, 0, 20'h06456, 4, 1));
        tv.push_back(mk(1, 32'h00009789, 0, 0, 0, 0, 0,  1, 1, 0, 20'h09789, 4, 1));
        // flush beats write; lookup in the flush cycle sees pre-flush table
        tv.push_back(mk(1, 32'h00009ABC, 0, 1, 20'h0000A, 8'h0A, 1,  1, 1, 0, 20'h09ABC, 0, 0));
        tv.push_back(mk(1, 32'h0000AABC, 0, 0, 0, 0, 0,  1, 0, 1, 20'h00000, 0, 0));
        tv.push_back(mk(1, 32'hFFFFFFFF, 1, 0, 0, 0, 0,  1, 1, 0, 20'hFFFFF, 0, 0));

        bus.lk_valid = 0; bus.lk_vaddr = '0; bus.lk_priv = 0;
        bus.wen = 0; bus.wr_vpn = '0; bus.wr_ppn = '0; bus.flush = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 64'(bus.rsp_valid), 0);
        chk("reset hit",   64'(bus.rsp_hit),   0);
        chk("reset miss",  64'(bus.rsp_miss),  0);
        chk("reset paddr", 64'(bus.rsp_paddr), 0);
        chk("reset occ",   64'(bus.occupancy), 0);
        rst = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].lv, tv[i].va, tv[i].pr, tv[i].w, tv[i].wv, tv[i].wp, tv[i].fl);
            chk($sformatf("r%0d valid", i), 64'(bus.rsp_valid), 64'(tv[i].ev));
            chk($sformatf("r%0d hit", i),   64'(bus.rsp_hit),   64'(tv[i].eh));
            chk($sformatf("r%0d miss", i),  64'(bus.rsp_miss),  64'(tv[i].em));
            chk($sformatf("r%0d paddr", i), 64'(bus.rsp_paddr), 64'(tv[i].ep));
            chk($sformatf("r%0d occ", i),   64'(bus.occupancy), 64'(tv[i].eo));
            chk($sformatf("r%0d vp", i),    64'(dut.vp),        64'(tv[i].evp));
        end

        // async reset with a lookup pending
        step(0, 0, 0, 1, 20'h00010, 8'h20, 0);
        step(1, 32'h00010ABC, 0, 1, 20'h00011, 8'h21, 0);
        chk("pre_rst paddr", 64'(bus.rsp_paddr), 64'h20ABC);
        #3 rst = 1'b0;
        m_reset();
        #1;
        chk("async valid", 64'(bus.rsp_valid), 0);
        chk("async hit",   64'(bus.rsp_hit),   0);
        chk("async paddr", 64'(bus.rsp_paddr), 0);
        chk("async occ",   64'(bus.occupancy), 0);
        bus.lk_valid = 0; bus.wen = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst valid", 64'(bus.rsp_valid), 0);
        step(1, 32'h00010ABC, 0, 0, 0, 0, 0);
        chk("post_rst miss10", 64'(bus.rsp_miss), 1);
        step(1, 32'h00011ABC, 0, 0, 0, 0, 0);
        chk("post_rst miss11", 64'(bus.rsp_miss), 1);
        chk_model("post_rst");

        // randomized traffic against the model
        for (int t = 0; t < 600; t++) begin
            rv = 20'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), {20'($urandom_range(0, 7)), 12'($urandom)},
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rv, 8'($urandom),
                 $urandom_range(0, 24) == 0);
            chk_model($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- Fully-associative translation buffer. It is the receiving end of the TLB write port that the writeback/commit stage drives: wen, vpn and ppn from TLBWRITE.
- It serves lookups from the fetch stage (iTLB instance) or the memory stage (dTLB instance) with a registered 1-cycle response.
- Replacement is round-robin. A supervisor-mode bypass gives identity translation.
- The design instantiates it twice, as itlb and dtlb.

Parameters:
- N_ENTRIES, 4, number of entries; power of two, at least 2.
- VPN_W, 20, virtual page number width.
- PPN_W, 8, physical page number width.
- OFFSET_W, 12, page offset width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- lk_valid  in  1  lookup request this cycle.
- lk_vaddr  in  VPN_W+OFFSET_W  virtual address to translate.
- lk_priv  in  1  supervisor mode (rm4 of the requesting thread); selects bypass.
- rsp_valid  out  1  response valid; asserted one cycle after lk_valid.
- rsp_hit  out  1  translation found, or bypass.
- rsp_miss  out  1  rsp_valid and not rsp_hit.
- rsp_paddr  out  PPN_W+OFFSET_W  physical address.
- wen  in  1  TLB write from commit.
- wr_vpn  in  VPN_W  page to install.
- wr_ppn  in  PPN_W  frame to install.
- flush  in  1  invalidate all entries.
- occupancy  out  $clog2(N_ENTRIES)+1  count of valid entries.

Behaviour:
- State:
  - valid[N_ENTRIES], vpn[N_ENTRIES], ppn[N_ENTRIES].
  - victim pointer vp, $clog2(N_ENTRIES) bits.
  - Registered response outputs.
- Reset (rst=0, asynchronous):
  - All valid bits 0, vp=0.
  - rsp_valid=0, rsp_hit=0, rsp_miss=0, rsp_paddr=0, occupancy=0.
  - vpn/ppn contents are don't-care.
  - Reset asserted mid-lookup drops the pending response: rsp_valid is 0 on the first edge after rst rises.
- Lookup, 1-cycle latency:
  - On an edge with lk_valid=1, the response registers are loaded and rsp_valid=1 next cycle; otherwise rsp_valid=0 and the other response outputs hold their last value.
  - lk_priv=1: rsp_hit=1, rsp_paddr=lk_vaddr[PPN_W+OFFSET_W-1:0] (truncating identity). No entry is consulted.
  - lk_priv=0: compare lk_vaddr[VPN_W+OFFSET_W-1:OFFSET_W] against every valid entry.
    - Match in entry i: rsp_hit=1, rsp_paddr={ppn[i], lk_vaddr[OFFSET_W-1:0]}.
    - No match: rsp_hit=0, rsp_paddr=0.
  - The lookup always sees the table state before the same-edge write or flush. No write-to-lookup forwarding; the caller retries, as commit does on a miss.
- Write (wen=1, flush=0), priority order:
  1. wr_vpn already valid in entry j: overwrite ppn[j] only. vp and occupancy unchanged.
  2. Otherwise, if any entry is invalid: install at the lowest-index invalid entry, set valid, occupancy+1. vp unchanged.
  3. Otherwise (full): install at entry vp, then vp = (vp+1) mod N_ENTRIES (wraps from N_ENTRIES-1 to 0). Occupancy stays N_ENTRIES.
- Invariant: at most one valid entry per vpn. A multiple match is unreachable; the bench asserts it never occurs.
- Flush: clears all valid bits, sets vp=0 and occupancy=0 on the edge. Flush dominates wen in the same cycle: the write is dropped.
- Occupancy is registered and equals popcount(valid) at all times.

Test Plan:
- Bypass and cold miss:
  - After reset, lookup vaddr=0x00402ABC with priv=1 -> next cycle rsp_valid=1, hit=1, paddr=0x02ABC.
  - Same lookup with priv=0 -> miss=1, paddr=0.
- Install and hit:
  - Write vpn=0x00402, ppn=0x1F.
  - Lookup 0x00402ABC next cycle -> hit, paddr=0x1FABC, occupancy=1.
  - Lookup in the same cycle as the write -> miss (no forwarding).
- Update in place: write vpn=0x00402 ppn=0x33 -> lookup gives paddr=0x33ABC; occupancy and vp unchanged.
- Fill and round-robin wrap (N_ENTRIES=4):
  - Write vpns 1,2,3,4 -> occupancy=4, vp=0.
  - Write vpns 5,6,7,8,9 -> they replace entries 0,1,2,3,0.
  - Lookup vpn 1 misses; vpns 6 and 9 hit; vp=1.
- Flush races:
  - flush and wen (vpn=0xA) in the same cycle -> occupancy=0, lookup 0xA misses, vp=0.
  - A lookup issued in the flush cycle still hits a pre-flush entry.
- Async reset mid-operation: assert rst=0 between edges with a lookup pending -> outputs clear immediately; no rsp_valid after release; all prior entries miss.
